wash_panel_ctrl: RTL and testbench
==================================

WASH_PANEL_CTRL -- requirements
Module: wash_panel_ctrl

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 4, meaning consecutive stable synchronized samples needed to change a debounced button level; legal range 1..15.
REQ-002 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports btn_start_raw, btn_pause_raw  input  1 each  raw asynchronous front-panel buttons, high = pressed.
REQ-005 SHALL have ports sw_double, sw_dry  input  1 each  raw asynchronous program selector switches.
REQ-006 SHALL have port door_closed  input  1  raw asynchronous door sensor, high = closed.
REQ-007 SHALL have port done  input  1  wash controller availability, high = idle.
REQ-008 SHALL have ports start, double_wash, dry_wash, time_pause  output  1 each  registered drives into the wash controller.
REQ-009 SHALL have ports busy, err_door  output  1 each  registered panel status.

Function
REQ-010 SHALL pass all six raw inputs through 2-flop synchronizers before any use.
REQ-011 SHALL debounce each synchronized button with a 4-bit counter: counter clears when input equals debounced level, else increments; debounced level flips and counter clears on the edge where counter reaches DEB_CYCLES.
REQ-012 SHALL derive a one-cycle press event from each debounced 0->1 transition.
REQ-013 SHALL implement FSM states READY, START, ACK, RUN; busy = (state != READY).
REQ-014 READY: start press with done=1 (and door closed, see REQ-027) SHALL capture synchronized sw_double/sw_dry into double_wash/dry_wash and go to START; otherwise stay.
REQ-015 START SHALL last exactly one cycle with start=1, then go to ACK; start SHALL be 0 in every other state.
REQ-016 ACK SHALL go to RUN on first cycle with done=0; otherwise stay.
REQ-017 RUN: done=1 SHALL go to READY and clear double_wash, dry_wash, time_pause.
REQ-018 In RUN a pause press SHALL toggle the user pause bit; time_pause SHALL equal that bit (plus REQ-028).
REQ-019 Pause presses outside RUN, and start presses outside READY, SHALL be ignored.
REQ-020 Pause press and done=1 in the same RUN cycle: transition to READY wins, time_pause=0.
REQ-021 double_wash and dry_wash SHALL stay constant from START until return to READY regardless of switch movement.
REQ-022 Raw start held stable high from before edge 1 SHALL produce start=1 in exactly the cycle after rising edge DEB_CYCLES+3.
REQ-023 A button glitch shorter than DEB_CYCLES synchronized cycles SHALL produce no press event.

Reset
REQ-024 rst_n low SHALL asynchronously force state READY, synchronizers, debounce counters and levels to 0, and outputs start, double_wash, dry_wash, time_pause, busy, err_door to 0.
REQ-025 Reset asserted mid-operation SHALL abandon the cycle; after release a fresh start press is required.
REQ-026 First press event after reset release SHALL need the full REQ-022 latency.

Configuration
REQ-027 With PANEL_DOOR_INTERLOCK_EN defined, a start press in READY with synchronized door_closed=0 SHALL be rejected (stay READY) and pulse err_door for one cycle.
REQ-028 With PANEL_DOOR_INTERLOCK_EN defined, in ACK/RUN synchronized door_closed=0 SHALL force time_pause=1 and err_door=1; on door close both revert (time_pause to user pause bit) next cycle.
REQ-029 Without PANEL_DOOR_INTERLOCK_EN, door_closed SHALL be ignored and err_door SHALL be constant 0.

Verification
REQ-030 DEB_CYCLES=4, done=1, door closed, sw_double=1, btn_start_raw high 20 cycles -> single start pulse in cycle after edge 7, double_wash=1, busy=1.
REQ-031 btn_start_raw high 3 cycles then low, DEB_CYCLES=4 -> no start, busy=0.
REQ-032 In RUN, two separated pause presses -> time_pause 0->1->0; then done=1 -> READY, all outputs 0.
REQ-033 In RUN, toggle sw_dry and sw_double -> dry_wash/double_wash unchanged until done=1.
REQ-034 PANEL_DOOR_INTERLOCK_EN: door open in READY plus start press -> no start, err_door one-cycle pulse; door opened in RUN -> time_pause=1, err_door=1 until closed.
REQ-035 rst_n low during RUN with time_pause=1 -> all outputs 0 immediately, state READY after release.

Source files
------------

// File: rtl/wash_panel_ctrl.sv
// Front-panel controller: synchronizes and debounces the panel inputs and sequences
// start/pause handshakes into the wash controller. Optional door interlock: PANEL_DOOR_INTERLOCK_EN.
module wash_panel_ctrl #(
  parameter int unsigned DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_start_raw,
  input  logic btn_pause_raw,
  input  logic sw_double,
  input  logic sw_dry,
  input  logic door_closed,
  input  logic done,
  output logic start,
  output logic double_wash,
  output logic dry_wash,
  output logic time_pause,
  output logic busy,
  output logic err_door
);

  localparam int unsigned N_SYNC = 6;
  localparam int unsigned N_BTN  = 2;
  localparam int unsigned CNT_W  = 4;
  localparam logic [CNT_W-1:0] DEB_LIM = CNT_W'(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

`ifdef PANEL_DOOR_INTERLOCK_EN
  localparam bit DOOR_IL = 1'b1;
`else
  localparam bit DOOR_IL = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_READY = 2'd0,
    ST_START = 2'd1,
    ST_ACK   = 2'd2,
    ST_RUN   = 2'd3
  } state_t;

  // Bit order: 0 start btn, 1 pause btn, 2 double sw, 3 dry sw, 4 door, 5 done
  logic [N_SYNC-1:0] w_raw;
  logic [N_SYNC-1:0] r_sync1;
  logic [N_SYNC-1:0] r_sync2;

  assign w_raw = {done, door_closed, sw_dry, sw_double, btn_pause_raw, btn_start_raw};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Debounce: level flips after DEB_CYCLES consecutive disagreeing samples
  logic [CNT_W-1:0] r_cnt [N_BTN];
  logic [N_BTN-1:0] r_lvl;
  logic [N_BTN-1:0] r_lvl_d;
  logic [N_BTN-1:0] w_press;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(N_BTN); i++) r_cnt[i] <= '0;
      r_lvl   <= '0;
      r_lvl_d <= '0;
    end else begin
      r_lvl_d <= r_lvl;
      for (int i = 0; i < int'(N_BTN); i++) begin
        if (r_sync2[i] == r_lvl[i]) begin
          r_cnt[i] <= '0;
        end else if ((r_cnt[i] + CNT_ONE) == DEB_LIM) begin
          r_cnt[i] <= '0;
          r_lvl[i] <= ~r_lvl[i];
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_ONE;
        end
      end
    end
  end

  assign w_press = r_lvl & ~r_lvl_d;

  logic w_start_press;
  logic w_pause_press;
  logic w_double_s;
  logic w_dry_s;
  logic w_door_s;
  logic w_done_s;

  assign w_start_press = w_press[0];
  assign w_pause_press = w_press[1];
  assign w_double_s    = r_sync2[2];
  assign w_dry_s       = r_sync2[3];
  assign w_door_s      = r_sync2[4];
  assign w_done_s      = r_sync2[5];

  state_t r_state;
  logic   r_upause;
  logic   r_start;
  logic   r_double;
  logic   r_dry;
  logic   r_tpause;
  logic   r_busy;
  logic   r_err;

  state_t w_state_nxt;
  logic   w_upause_nxt;
  logic   w_double_nxt;
  logic   w_dry_nxt;
  logic   w_reject;
  logic   w_door_alarm;
  logic   w_start_nxt;
  logic   w_tpause_nxt;
  logic   w_busy_nxt;
  logic   w_err_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_READY;
      r_upause <= 1'b0;
      r_start  <= 1'b0;
      r_double <= 1'b0;
      r_dry    <= 1'b0;
      r_tpause <= 1'b0;
      r_busy   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_upause <= w_upause_nxt;
      r_start  <= w_start_nxt;
      r_double <= w_double_nxt;
      r_dry    <= w_dry_nxt;
      r_tpause <= w_tpause_nxt;
      r_busy   <= w_busy_nxt;
      r_err    <= w_err_nxt;
    end
  end

  // Outputs are registered from the next-state values so they track the state exactly
  always_comb begin
    w_state_nxt  = r_state;
    w_upause_nxt = r_upause;
    w_double_nxt = r_double;
    w_dry_nxt    = r_dry;
    w_reject     = 1'b0;
    case (r_state)
      ST_READY: begin
        if (w_start_press) begin
          if (DOOR_IL && !w_door_s) begin
            w_reject = 1'b1;
          end else if (w_done_s) begin
            w_state_nxt  = ST_START;
            w_double_nxt = w_double_s;
            w_dry_nxt    = w_dry_s;
          end
        end
      end
      ST_START: w_state_nxt = ST_ACK;
      ST_ACK: begin
        if (!w_done_s) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (w_done_s) begin
          w_state_nxt  = ST_READY;
          w_upause_nxt = 1'b0;
          w_double_nxt = 1'b0;
          w_dry_nxt    = 1'b0;
        end else if (w_pause_press) begin
          w_upause_nxt = ~r_upause;
        end
      end
      default: w_state_nxt = ST_READY;
    endcase
    w_door_alarm = DOOR_IL && !w_door_s &&
                   ((w_state_nxt == ST_ACK) || (w_state_nxt == ST_RUN));
    w_start_nxt  = (w_state_nxt == ST_START);
    w_busy_nxt   = (w_state_nxt != ST_READY);
    w_tpause_nxt = w_upause_nxt | w_door_alarm;
    w_err_nxt    = w_reject | w_door_alarm;
  end

  assign start       = r_start;
  assign double_wash = r_double;
  assign dry_wash    = r_dry;
  assign time_pause  = r_tpause;
  assign busy        = r_busy;
  assign err_door    = r_err;

endmodule

// File: tb/tb_wash_panel_ctrl.sv
// Bench for wash_panel_ctrl: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against a behavioural panel model.
module tb_wash_panel_ctrl;

  localparam int DEB = 4;
`ifdef PANEL_DOOR_INTERLOCK_EN
  localparam bit IL = 1'b1;
`else
  localparam bit IL = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_s = 1'b0, btn_p = 1'b0, sw_d = 1'b0, sw_y = 1'b0, door = 1'b1, done_i = 1'b1;
  logic start, double_wash, dry_wash, time_pause, busy, err_door;

  int total = 0;
  int bad = 0;

  wash_panel_ctrl #(.DEB_CYCLES(DEB)) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_start_raw(btn_s), .btn_pause_raw(btn_p),
    .sw_double(sw_d), .sw_dry(sw_y), .door_closed(door), .done(done_i),
    .start(start), .double_wash(double_wash), .dry_wash(dry_wash),
    .time_pause(time_pause), .busy(busy), .err_door(err_door)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: inputs seen two edges late, buttons count disagreeing runs,
  // a press acts one edge after the debounced rise.
  logic [5:0] m_h1, m_h2, m_in;
  bit   m_lvl [2];
  int   m_run [2];
  bit   m_pp  [2];
  int   m_mode;   // 0 idle, 1 start pulse, 2 waiting for controller, 3 washing
  bit   m_up, m_dbl, m_dry, m_start, m_busy, m_tp, m_err, m_rej, m_alarm;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_h1 = '0; m_h2 = '0;
      for (int b = 0; b < 2; b++) begin m_lvl[b] = 0; m_run[b] = 0; m_pp[b] = 0; end
      m_mode = 0; m_up = 0; m_dbl = 0; m_dry = 0;
      m_start = 0; m_busy = 0; m_tp = 0; m_err = 0;
    end else begin
      m_in = m_h2;
      m_h2 = m_h1;
      m_h1 = {done_i, door, sw_y, sw_d, btn_p, btn_s};
      m_rej = 0;
      if (m_mode == 0) begin
        if (m_pp[0]) begin
          if (IL && !m_in[4]) m_rej = 1;
          else if (m_in[5]) begin m_mode = 1; m_dbl = m_in[2]; m_dry = m_in[3]; end
        end
      end else if (m_mode == 1) begin
        m_mode = 2;
      end else if (m_mode == 2) begin
        if (!m_in[5]) m_mode = 3;
      end else begin
        if (m_in[5]) begin m_mode = 0; m_up = 0; m_dbl = 0; m_dry = 0; end
        else if (m_pp[1]) m_up = !m_up;
      end
      for (int b = 0; b < 2; b++) begin
        m_pp[b] = 0;
        if (m_in[b] != m_lvl[b]) begin
          m_run[b]++;
          if (m_run[b] == DEB) begin
            m_lvl[b] = !m_lvl[b];
            m_run[b] = 0;
            m_pp[b] = m_lvl[b];
          end
        end else m_run[b] = 0;
      end
      m_alarm = IL && !m_in[4] && (m_mode == 2 || m_mode == 3);
      m_start = (m_mode == 1);
      m_busy  = (m_mode != 0);
      m_tp    = m_up | m_alarm;
      m_err   = m_rej | m_alarm;
    end
  end

  always @(negedge clk) begin
    chk("m_start", start, m_start);
    chk("m_busy", busy, m_busy);
    chk("m_double", double_wash, m_dbl);
    chk("m_dry", dry_wash, m_dry);
    chk("m_tpause", time_pause, m_tp);
    chk("m_err", err_door, m_err);
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press_pause();
    btn_p = 1'b1; cyc(8);
    btn_p = 1'b0; cyc(8);
  endtask

  task automatic all_zero(input string nm);
    chk({nm, "_start"}, start, 1'b0);
    chk({nm, "_double"}, double_wash, 1'b0);
    chk({nm, "_dry"}, dry_wash, 1'b0);
    chk({nm, "_tpause"}, time_pause, 1'b0);
    chk({nm, "_busy"}, busy, 1'b0);
    chk({nm, "_err"}, err_door, 1'b0);
  endtask

  int  err_cnt;
  bit  saw_start;

  initial begin
    sw_d = 1'b1; btn_s = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    all_zero("reset");
    rst_n = 1'b1;

    // Start held from before edge 1: pulse in the cycle after edge DEB+3
    cyc(DEB + 2); chk("start_early", start, 1'b0);
    cyc(1);
    chk("start_pulse", start, 1'b1);
    chk("start_busy", busy, 1'b1);
    chk("start_double", double_wash, 1'b1);
    chk("start_dry", dry_wash, 1'b0);
    cyc(1);
    chk("start_single", start, 1'b0);
    chk("ack_busy", busy, 1'b1);
    cyc(12); btn_s = 1'b0;

    done_i = 1'b0; cyc(4);
    press_pause(); chk("pause_on", time_pause, 1'b1);
    sw_d = 1'b0; sw_y = 1'b1; cyc(6);
    chk("hold_double", double_wash, 1'b1);
    chk("hold_dry", dry_wash, 1'b0);
    press_pause(); chk("pause_off", time_pause, 1'b0);
    done_i = 1'b1; cyc(4);
    all_zero("finish");

    // Short glitch must not start anything
    saw_start = 0;
    btn_s = 1'b1; cyc(DEB - 1); btn_s = 1'b0;
    for (int i = 0; i < 12; i++) begin cyc(1); if (start) saw_start = 1; end
    chk("glitch_start", saw_start, 1'b0);
    chk("glitch_busy", busy, 1'b0);

    // Reset while washing and paused
    btn_s = 1'b1; cyc(8); btn_s = 1'b0; cyc(2);
    chk("run2_dry", dry_wash, 1'b1);
    done_i = 1'b0; cyc(6);
    press_pause(); chk("run2_pause", time_pause, 1'b1);
    #2 rst_n = 1'b0;
    #1 all_zero("async_rst");
    @(posedge clk); #1 rst_n = 1'b1; done_i = 1'b1;
    cyc(12); chk("post_rst_idle", busy, 1'b0);

`ifdef PANEL_DOOR_INTERLOCK_EN
    err_cnt = 0; saw_start = 0;
    door = 1'b0; btn_s = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i == 8) btn_s = 1'b0;
      cyc(1); err_cnt += int'(err_door); if (start) saw_start = 1;
    end
    chk("il_no_start", saw_start, 1'b0);
    chk("il_err_once", err_cnt == 1, 1'b1);
    door = 1'b1; cyc(4);
    btn_s = 1'b1; cyc(8); btn_s = 1'b0; done_i = 1'b0; cyc(6);
    door = 1'b0; cyc(4);
    chk("il_open_tp", time_pause, 1'b1);
    chk("il_open_err", err_door, 1'b1);
    door = 1'b1; cyc(4);
    chk("il_close_tp", time_pause, 1'b0);
    chk("il_close_err", err_door, 1'b0);
    done_i = 1'b1; cyc(4);
`endif

    // Randomized run: button toggles give a mix of glitches and real presses
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(5, 0) == 0) btn_s = ~btn_s;
      if ($urandom_range(5, 0) == 0) btn_p = ~btn_p;
      if ($urandom_range(19, 0) == 0) done_i = ~done_i;
      if ($urandom_range(29, 0) == 0) sw_d = ~sw_d;
      if ($urandom_range(29, 0) == 0) sw_y = ~sw_y;
      if ($urandom_range(24, 0) == 0) door = ~door;
      if ($urandom_range(799, 0) == 0) begin
        rst_n = 1'b0; cyc(2); rst_n = 1'b1;
      end
      cyc(1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
